// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder controller around one full-adder cell.
//
// Accepts two WIDTH-bit operands plus carry-in with a start/in_ready handshake.
// It feeds Full_Adder_Structural one bit pair per cycle, LSB first. The running
// carry is held in a flop and the sum bits are collected in a shift register.
// The result is presented with an out_valid/out_ready handshake.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, this adds input `sub`, which is sampled at accept.
//   With sub=1 the result is a-b mod 2^WIDTH, and cout=1 means no borrow.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   start, in_ready input request handshake (in_ready high only in IDLE)
//   a, b, cin       operands and carry-in, sampled on the accept edge
//   out_valid       result held (DONE)
//   out_ready       consumer accepts result
//   sum, cout       registered result, updated only on RUN->DONE
//   busy            high in RUN

module Full_Adder_Structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);
  logic ab_x, ab_a, c_a;
  xor g0 (ab_x, a, b);
  xor g1 (sum, ab_x, cin);
  and g2 (ab_a, a, b);
  and g3 (c_a, ab_x, cin);
  or  g4 (cout, ab_a, c_a);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh;
  // Collected sum bits. It is one bit narrower than WIDTH because the final
  // bit goes straight into `sum` and never has to be stored here.
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             accept, last;
  logic             cell_b, cell_sum, cell_cout;
  logic [WIDTH-1:0] sum_nxt;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  // Subtraction: a + ~b + 1. The +1 comes from carry, which is preset at accept.
  assign cell_b = b_sh[0] ^ sub_q;
`else
  assign cell_b = b_sh[0];
`endif

  Full_Adder_Structural u_fa (
    .a    (a_sh[0]),
    .b    (cell_b),
    .cin  (carry),
    .cout (cell_cout),
    .sum  (cell_sum)
  );

  // The new bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
  assign sum_nxt = {cell_sum, sum_sh};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= sub;
      carry <= sub ? 1'b1 : cin;
`else
      carry <= cin;
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nxt[WIDTH-1:1];
      carry  <= cell_cout;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum  <= sum_nxt;
        cout <= cell_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Stimulus only: present operands at a negedge and pulse start across one
  // rising edge. The caller must already be in IDLE.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = vs;
`else
    if (vs) $display("[TB] sub ignored in add-only build");
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts rising edges until out_valid, bounded at 40.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    #12;
    tests++;
    if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failed++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b sum=%h cout=%b, want 1 0 0 00 0",
               in_ready, out_valid, busy, sum, cout);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int cyc;
    launch(8'h3C, 8'h05, 1'b0, 1'b0);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failed++; $display("FAIL basic_run_flags: busy=%b rdy=%b, want 1 0", busy, in_ready);
    end
    wait_valid(cyc);
    tests++;
    if (cyc !== W) begin failed++; $display("FAIL basic_latency: got %0d, want %0d", cyc, W); end
    tests++;
    if (sum !== 8'h41 || cout !== 1'b0) begin
      failed++; $display("FAIL basic_result: got %h/%b, want 41/0", sum, cout);
    end
    release_result();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failed++; $display("FAIL basic_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
    logic         vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [3] = '{8'h00, 8'hFF, 8'h01};
    logic         ec [3] = '{1'b1, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vc[i], 1'b0);
      wait_valid(cyc);
      tests++;
      if (!out_valid || sum !== es[i] || cout !== ec[i]) begin
        failed++;
        $display("FAIL carry_%0d: vld=%b got %h/%b, want %h/%b", i, out_valid, sum, cout, es[i], ec[i]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    launch(8'h55, 8'hAA, 1'b0, 1'b0);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (!out_valid || in_ready || sum !== 8'hFF || cout !== 1'b0) begin
        failed++;
        $display("FAIL backpressure_%0d: vld=%b rdy=%b got %h/%b, want 1 0 ff/0",
                 i, out_valid, in_ready, sum, cout);
      end
    end
    @(negedge clk); start = 1'b0;
    release_result();
    tests++;
    if (!in_ready || out_valid || busy || sum !== 8'hFF) begin
      failed++;
      $display("FAIL backpressure_release: rdy=%b vld=%b busy=%b sum=%h, want 1 0 0 ff",
               in_ready, out_valid, busy, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3] = '{8'h10, 8'h80, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h20, 8'h80, 8'h01};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [3] = '{8'h30, 8'h00, 8'h81};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    int cyc;
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (!busy) begin failed++; $display("FAIL b2b_accept_%0d: busy=%b, want 1", i, busy); end
      wait_valid(cyc);
      tests++;
      if (cyc !== W || sum !== es[i] || cout !== ec[i]) begin
        failed++;
        $display("FAIL b2b_result_%0d: cyc=%0d got %h/%b, want %0d %h/%b",
                 i, cyc, sum, cout, W, es[i], ec[i]);
      end
      // The handshake edge takes the FSM back to IDLE; the following edge accepts.
      @(posedge clk); #1;
      tests++;
      if (!in_ready) begin failed++; $display("FAIL b2b_idle_%0d: rdy=%b, want 1", i, in_ready); end
      if (i < 2) begin a = va[i+1]; b = vb[i+1]; cin = vc[i+1]; end
      else start = 1'b0;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    launch(8'hF0, 8'h0F, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failed++;
      $display("FAIL midrun_reset: rdy=%b vld=%b busy=%b sum=%h cout=%b, want 1 0 0 00 0",
               in_ready, out_valid, busy, sum, cout);
    end
    @(negedge clk); rst = 1'b0;
    wait_valid(cyc);
    tests++;
    if (out_valid) begin failed++; $display("FAIL midrun_no_pulse: vld=%b, want 0", out_valid); end
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid(cyc);
    tests++;
    if (!out_valid || sum !== 8'h46 || cout !== 1'b0) begin
      failed++; $display("FAIL midrun_after: vld=%b got %h/%b, want 1 46/0", out_valid, sum, cout);
    end
    release_result();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [W-1:0] va [3] = '{8'h10, 8'h03, 8'h03};
    logic [W-1:0] vb [3] = '{8'h03, 8'h10, 8'h10};
    logic         vs [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] es [3] = '{8'h0D, 8'hF3, 8'h13};
    logic         ec [3] = '{1'b1, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], 1'b0, vs[i]);
      wait_valid(cyc);
      tests++;
      if (!out_valid || sum !== es[i] || cout !== ec[i]) begin
        failed++;
        $display("FAIL sub_%0d: vld=%b got %h/%b, want %h/%b", i, out_valid, sum, cout, es[i], ec[i]);
      end
      release_result();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
